mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/grant bundle between the processors and the memory arbiter.
// The processors drive the requests; the arbiter drives the grant side.
interface mem_arbiter_if #(
   parameter int PORT_COUNT = 4
);
   localparam int SW = $clog2(PORT_COUNT);

   logic [PORT_COUNT-1:0] i_req_rd;
   logic [PORT_COUNT-1:0] i_req_wr;
   logic [PORT_COUNT-1:0] o_grant_rd;
   logic [PORT_COUNT-1:0] o_grant_wr;
   logic [SW-1:0]         o_sel;
   logic                  o_busy;

   modport master (
      output i_req_rd,
      output i_req_wr,
      input  o_grant_rd,
      input  o_grant_wr,
      input  o_sel,
      input  o_busy
   );

   modport slave (
      input  i_req_rd,
      input  i_req_wr,
      output o_grant_rd,
      output o_grant_wr,
      output o_sel,
      output o_busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin read/write memory arbiter with a bounded hold time
// and a mandatory idle bubble between grants.
module mem_arbiter #(
   parameter int PORT_COUNT = 4,
   parameter int MAX_HOLD   = 8
) (
   input logic          i_clk,
   input logic          i_rst,
   mem_arbiter_if.slave bus
);
   localparam int SW = $clog2(PORT_COUNT);

   typedef enum logic [1:0] {
      IDLE,
      GNT_RD,
      GNT_WR
   } state_t;

   state_t                state;
   logic [SW-1:0]         rr_ptr;
   logic [SW-1:0]         sel;
   logic [SW-1:0]         win;
   logic [SW-1:0]         next_ptr;
   logic [7:0]            hold_cnt;
   logic [PORT_COUNT-1:0] grant_rd;
   logic [PORT_COUNT-1:0] grant_wr;
   logic [PORT_COUNT-1:0] elig;
   logic [PORT_COUNT-1:0] win_oh;
   logic                  busy;
   logic                  found;
   logic                  keep;
   logic                  hold_max;
   int                    idx;

   assign elig = bus.i_req_rd | bus.i_req_wr;

   // First eligible port at or after rr_ptr, wrapping modulo PORT_COUNT.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int i = 0; i < PORT_COUNT; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= PORT_COUNT) idx = idx - PORT_COUNT;
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = SW'(idx);
         end
      end
   end

   assign win_oh   = PORT_COUNT'(1) << win;
   assign next_ptr = (win == SW'(PORT_COUNT - 1)) ? '0 : win + SW'(1);
   assign hold_max = (hold_cnt == 8'(MAX_HOLD - 1));

   always_comb begin
      keep = 1'b0;
      if (state == GNT_RD) keep = bus.i_req_rd[sel];
      if (state == GNT_WR) keep = bus.i_req_wr[sel];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         hold_cnt <= '0;
         grant_rd <= '0;
         grant_wr <= '0;
         sel      <= '0;
         busy     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  // Write wins when the port asks for both.
                  if (bus.i_req_wr[win]) begin
                     state    <= GNT_WR;
                     grant_wr <= win_oh;
                     grant_rd <= '0;
                  end else begin
                     state    <= GNT_RD;
                     grant_rd <= win_oh;
                     grant_wr <= '0;
                  end
                  sel      <= win;
                  rr_ptr   <= next_ptr;
                  hold_cnt <= '0;
                  busy     <= 1'b1;
               end
            end
            GNT_RD, GNT_WR: begin
               if (!keep || hold_max) begin
                  state    <= IDLE;
                  grant_rd <= '0;
                  grant_wr <= '0;
                  sel      <= '0;
                  busy     <= 1'b0;
                  hold_cnt <= '0;
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_grant_rd = grant_rd;
   assign bus.o_grant_wr = grant_wr;
   assign bus.o_sel      = sel;
   assign bus.o_busy     = busy;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random checks for mem_arbiter with 4 ports and
// a hold limit of 8 cycles.
module tb_mem_arbiter;
   localparam int P  = 4;
   localparam int MH = 8;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   mem_arbiter_if #(.PORT_COUNT(P)) bus ();

   mem_arbiter #(
      .PORT_COUNT(P),
      .MAX_HOLD  (MH)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [3:0] rd,
                            input logic [3:0] wr, input logic [1:0] sel,
                            input logic busy);
      check({tag, ".rd"}, 32'(bus.o_grant_rd), 32'(rd));
      check({tag, ".wr"}, 32'(bus.o_grant_wr), 32'(wr));
      check({tag, ".sel"}, 32'(bus.o_sel), 32'(sel));
      check({tag, ".busy"}, 32'(bus.o_busy), 32'(busy));
   endtask

   initial begin
      logic [3:0] elig_prev;
      logic [3:0] g;
      int         run;
      int         wait_c [P];

      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.i_req_rd = '0;
      bus.i_req_wr = '0;

      // Reset state and quiet idle
      tick();
      tick();
      check_out("reset", 4'b0, 4'b0, 2'd0, 1'b0);
      rst = 1'b0;
      tick();
      tick();
      check_out("idle_quiet", 4'b0, 4'b0, 2'd0, 1'b0);

      // Single reader on port 2, full hold then regrant after bubble
      bus.i_req_rd = 4'b0100;
      tick();
      check_out("p2_grant", 4'b0100, 4'b0, 2'd2, 1'b1);
      repeat (7) tick();
      check_out("p2_last", 4'b0100, 4'b0, 2'd2, 1'b1);
      tick();
      check_out("p2_bubble", 4'b0, 4'b0, 2'd0, 1'b0);
      tick();
      check_out("p2_regrant", 4'b0100, 4'b0, 2'd2, 1'b1);
      bus.i_req_rd = '0;
      tick();
      check_out("p2_drop", 4'b0, 4'b0, 2'd0, 1'b0);

      // Port 0 drops its request after 3 granted cycles
      bus.i_req_rd = 4'b0001;
      tick();
      check_out("p0_grant", 4'b0001, 4'b0, 2'd0, 1'b1);
      repeat (2) tick();
      check_out("p0_third", 4'b0001, 4'b0, 2'd0, 1'b1);
      bus.i_req_rd = '0;
      tick();
      check_out("p0_release", 4'b0, 4'b0, 2'd0, 1'b0);

      // All four read continuously: 0,1,2,3,0 with 8-cycle grants
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.i_req_rd = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         check_out($sformatf("rr%0d_on", k), 4'(1 << (k % 4)), 4'b0,
                   2'(k % 4), 1'b1);
         repeat (7) tick();
         check_out($sformatf("rr%0d_hold", k), 4'(1 << (k % 4)), 4'b0,
                   2'(k % 4), 1'b1);
         tick();
         check_out($sformatf("rr%0d_bub", k), 4'b0, 4'b0, 2'd0, 1'b0);
      end
      bus.i_req_rd = '0;
      tick();

      // Port 1 asks for both: write first, read later in RR order
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.i_req_rd = 4'b0010;
      bus.i_req_wr = 4'b0010;
      tick();
      check_out("both_wr", 4'b0, 4'b0010, 2'd1, 1'b1);
      bus.i_req_rd = 4'b0011;
      tick();
      check_out("both_other", 4'b0, 4'b0010, 2'd1, 1'b1);
      bus.i_req_wr = '0;
      tick();
      check_out("both_wrdrop", 4'b0, 4'b0, 2'd0, 1'b0);
      tick();
      check_out("both_p0rd", 4'b0001, 4'b0, 2'd0, 1'b1);
      bus.i_req_rd = 4'b0010;
      tick();
      check_out("both_p0drop", 4'b0, 4'b0, 2'd0, 1'b0);
      tick();
      check_out("both_p1rd", 4'b0010, 4'b0, 2'd1, 1'b1);
      bus.i_req_rd = '0;
      tick();

      // Reset in the middle of a write grant on port 3
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.i_req_wr = 4'b1000;
      tick();
      check_out("p3_wr", 4'b0, 4'b1000, 2'd3, 1'b1);
      tick();
      bus.i_req_rd = 4'b0001;
      rst = 1'b1;
      tick();
      check_out("midrst", 4'b0, 4'b0, 2'd0, 1'b0);
      rst = 1'b0;
      tick();
      check_out("postrst", 4'b0001, 4'b0, 2'd0, 1'b1);
      bus.i_req_rd = '0;
      bus.i_req_wr = '0;
      tick();
      tick();

      // Random sticky requests with invariant checks
      run = 0;
      elig_prev = '0;
      for (int p = 0; p < P; p++) wait_c[p] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < P; p++) begin
            if ($urandom_range(15) == 0) bus.i_req_rd[p] = ~bus.i_req_rd[p];
            if ($urandom_range(15) == 0) bus.i_req_wr[p] = ~bus.i_req_wr[p];
         end
         elig_prev = bus.i_req_rd | bus.i_req_wr;
         tick();
         g = bus.o_grant_rd | bus.o_grant_wr;
         check("rand_onehot", 32'($onehot0({bus.o_grant_rd, bus.o_grant_wr})),
               32'd1);
         check("rand_busy", 32'(bus.o_busy), 32'(g != '0));
         run = (g != '0) ? run + 1 : 0;
         check("rand_hold", 32'(run <= MH), 32'd1);
         for (int p = 0; p < P; p++) begin
            if (g[p]) wait_c[p] = 0;
            else if (elig_prev[p]) wait_c[p]++;
            else wait_c[p] = 0;
            check($sformatf("rand_starve%0d", p),
                  32'(wait_c[p] <= P * (MH + 1)), 32'd1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
